conv2d_stream_engine: RTL and testbench
=======================================

CONV2D_STREAM_ENGINE -- requirements
Module: conv2d_stream_engine

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 1024: input frame width in pixels (>= KERNEL_SIZE).
REQ-002 SHALL have parameter IMG_HEIGHT, default 1024: input frame height in rows (>= KERNEL_SIZE).
REQ-003 SHALL have parameter KERNEL_SIZE, default 4: square kernel dimension K, range 2..8.
REQ-004 SHALL have parameter PIX_WIDTH, default 8: unsigned pixel and coefficient width.
REQ-005 SHALL have parameter ACC_WIDTH, default 2*PIX_WIDTH+$clog2(K*K): accumulator width.
REQ-006 SHALL have port clk, input, 1: single clock; all logic on the rising edge.
REQ-007 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-008 SHALL have port start, input, 1: one-cycle frame-start pulse, honoured only in IDLE.
REQ-009 SHALL have port cfg_shift, input, 5: right shift applied to the accumulator; sampled at start.
REQ-010 SHALL have port cfg_saturate, input, 1: 1 = clamp, 0 = truncate; sampled at start.
REQ-011 SHALL have port k_valid, input, 1: kernel coefficient valid.
REQ-012 SHALL have port k_data, input, PIX_WIDTH: coefficient; raster order, row 0 column 0 first.
REQ-013 SHALL have port k_ready, output, 1: high in KLOAD only.
REQ-014 SHALL have port in_valid, input, 1: pixel valid.
REQ-015 SHALL have port in_data, input, PIX_WIDTH: pixel; raster order.
REQ-016 SHALL have port in_ready, output, 1: pixel accepted when in_valid && in_ready.
REQ-017 SHALL have port out_valid, input/output as output, 1: result valid.
REQ-018 SHALL have port out_data, output, PIX_WIDTH: post-processed result.
REQ-019 SHALL have port out_ready, input, 1: downstream accept.
REQ-020 SHALL have port busy, output, 1: state != IDLE.
REQ-021 SHALL have port done, output, 1: one-cycle pulse after the final result is accepted.

Function
REQ-022 SHALL implement FSM IDLE -> KLOAD on start; KLOAD -> RUN after K*K coefficient handshakes; RUN -> DRAIN after the last pixel (IMG_WIDTH*IMG_HEIGHT) is accepted; DRAIN -> IDLE once the pipeline is empty and the final result is accepted, asserting done in that cycle.
REQ-023 SHALL produce "valid" convolution only: (IMG_WIDTH-K+1)*(IMG_HEIGHT-K+1) results in raster order; result(r,c) = sum over i,j of kernel[i][j] * pix[r+i][c+j].
REQ-024 SHALL buffer K-1 previous rows of IMG_WIDTH pixels plus a KxK window register; a window is valid when row_cnt >= K-1 and col_cnt >= K-1.
REQ-025 SHALL use a two-stage pipeline (stage 1: K*K products registered; stage 2: adder tree + shift/clamp registered): out_valid rises 2 advancing cycles after the completing pixel is accepted.
REQ-026 SHALL advance the pipeline only when !out_valid || out_ready; in_ready = (state==RUN) && advance; out_data is held stable while out_valid && !out_ready.
REQ-027 SHALL form post = acc >> cfg_shift; with saturate, out = (post > 2^PIX_WIDTH-1) ? all-ones : post; otherwise out = post[PIX_WIDTH-1:0].
REQ-028 SHALL run the column counter 0..IMG_WIDTH-1 and wrap to 0 while incrementing the row counter; column windows do not span the row wrap (no output for col_cnt < K-1).
REQ-029 SHALL ignore start outside IDLE, and k_valid outside KLOAD.

Reset
REQ-030 SHALL on reset return to IDLE; counters, pipeline valids, out_valid, done, busy, k_ready and in_ready = 0; out_data = 0; reset mid-frame aborts the frame with no done pulse.
REQ-031 SHALL NOT reset the line-buffer storage or kernel storage; both are overwritten before use.

Structure
REQ-032 SHALL place the state enum (IDLE, KLOAD, RUN, DRAIN) and the ACC_WIDTH derivation function in the shared package conv_pkg.
REQ-033 SHALL implement the row storage as one sub-module, conv_line_buffer (K-1 rows x IMG_WIDTH, one write and K-1 parallel reads per cycle).

Verification
REQ-034 IMG 8x8, K=4, kernel all 1, pixels all 1, shift 0 -> 25 results, each = 16; done after the 25th is accepted.
REQ-035 IMG 8x8, kernel identity at [0][0]=1, pixel = index mod 256 -> result(r,c) = pix[r][c].
REQ-036 kernel all 255, pixels all 255, saturate=1, shift=0 -> every out_data = 255; with saturate=0 -> out_data = (16*65025) mod 256 = 16.
REQ-037 Random out_ready at 30% duty -> result stream identical to the full-rate run; out_data is stable during every stall.
REQ-038 Reset asserted after 20 pixels -> next cycle busy=0 and out_valid=0; a following full frame is correct.
REQ-039 start pulsed during RUN, and k_valid asserted during RUN -> no effect on results or counts.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared definitions for the streaming 2-D convolution engine:
// controller state encodings and the accumulator width derivation.
package conv_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] KLOAD = 2'd1;
    localparam logic [1:0] RUN   = 2'd2;
    localparam logic [1:0] DRAIN = 2'd3;

    function automatic int clog2_int(input int value);
        int bits;
        bits = 0;
        while ((1 << bits) < value) begin
            bits++;
        end
        return bits;
    endfunction

    // Wide enough to sum K*K full-scale products without overflow.
    function automatic int acc_width(input int pix_width, input int kernel_size);
        return 2 * pix_width + clog2_int(kernel_size * kernel_size);
    endfunction

endpackage

// File: rtl/conv2d_stream_engine_if.sv
// Coefficient, pixel and result valid/ready channels of the convolution engine.
// The master side feeds kernel and pixels and accepts results; the engine is the slave.
interface conv2d_stream_engine_if #(
    parameter int PIX_WIDTH = 8
);
    logic                 k_valid;
    logic                 k_ready;
    logic [PIX_WIDTH-1:0] k_data;

    logic                 in_valid;
    logic                 in_ready;
    logic [PIX_WIDTH-1:0] in_data;

    logic                 out_valid;
    logic                 out_ready;
    logic [PIX_WIDTH-1:0] out_data;

    modport master (
        output k_valid, k_data, in_valid, in_data, out_ready,
        input  k_ready, in_ready, out_valid, out_data
    );

    modport slave (
        input  k_valid, k_data, in_valid, in_data, out_ready,
        output k_ready, in_ready, out_valid, out_data
    );

endinterface

// File: rtl/conv_line_buffer.sv
// Holds the K-1 most recent image rows; each write pushes the new pixel into the
// newest row and shifts the older pixels of that column one row further back.
module conv_line_buffer #(
    parameter int IMG_WIDTH   = 1024,
    parameter int KERNEL_SIZE = 4,
    parameter int PIX_WIDTH   = 8
) (
    input  logic                                   clk,
    input  logic                                   wr_en,
    input  logic [$clog2(IMG_WIDTH)-1:0]           addr,
    input  logic [PIX_WIDTH-1:0]                   wr_data,
    output logic [KERNEL_SIZE-2:0][PIX_WIDTH-1:0]  rd_data
);

    localparam int ROWS = KERNEL_SIZE - 1;

    logic [PIX_WIDTH-1:0] mem_q [ROWS][IMG_WIDTH];

    // rd_data[0] is the row just above the incoming pixel, rd_data[ROWS-1] the oldest.
    always_comb begin
        for (int r = 0; r < ROWS; r++) begin
            rd_data[r] = mem_q[r][addr];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[0][addr] <= wr_data;
            for (int r = 1; r < ROWS; r++) begin
                mem_q[r][addr] <= mem_q[r-1][addr];
            end
        end
    end

endmodule

// File: rtl/conv2d_stream_engine.sv
// Streaming KxK "valid" 2-D convolution over a raster pixel stream: a per-frame
// kernel load, a window register fed from the line buffer, then product and sum stages.
module conv2d_stream_engine
    import conv_pkg::*;
#(
    parameter int IMG_WIDTH   = 1024,
    parameter int IMG_HEIGHT  = 1024,
    parameter int KERNEL_SIZE = 4,
    parameter int PIX_WIDTH   = 8,
    parameter int ACC_WIDTH   = acc_width(PIX_WIDTH, KERNEL_SIZE)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [4:0]             cfg_shift,
    input  logic                   cfg_saturate,
    conv2d_stream_engine_if.slave  bus,
    output logic                   busy,
    output logic                   done
);

    localparam int KK  = KERNEL_SIZE * KERNEL_SIZE;
    localparam int CW  = $clog2(IMG_WIDTH);
    localparam int RW  = $clog2(IMG_HEIGHT);
    localparam int KW  = $clog2(KK);
    localparam int PRW = 2 * PIX_WIDTH;
    localparam logic [ACC_WIDTH-1:0] PIX_MAX = ACC_WIDTH'({PIX_WIDTH{1'b1}});

    logic [1:0]           state_q, state_d;
    logic [KW-1:0]        k_cnt_q, k_cnt_d;
    logic [CW-1:0]        col_cnt_q, col_cnt_d;
    logic [RW-1:0]        row_cnt_q, row_cnt_d;
    logic [4:0]           shift_q, shift_d;
    logic                 sat_q, sat_d;
    logic                 done_q, done_d;

    logic                 win_valid_q, win_valid_d;
    logic                 s1_valid_q, s1_valid_d;
    logic                 out_valid_q, out_valid_d;
    logic [PIX_WIDTH-1:0] out_data_q, out_data_d;

    logic [PIX_WIDTH-1:0] kern_q [KK];
    logic [PIX_WIDTH-1:0] kern_d [KK];
    logic [PIX_WIDTH-1:0] win_q [KERNEL_SIZE][KERNEL_SIZE];
    logic [PIX_WIDTH-1:0] win_d [KERNEL_SIZE][KERNEL_SIZE];
    logic [PRW-1:0]       prod_q [KK];
    logic [PRW-1:0]       prod_d [KK];

    logic [KERNEL_SIZE-2:0][PIX_WIDTH-1:0] lb_rd;

    logic                 advance;
    logic                 in_ready;
    logic                 accept;
    logic                 k_fire;
    logic                 win_pos_ok;
    logic                 last_col;
    logic                 last_row;
    logic                 pipe_empty;
    logic [ACC_WIDTH-1:0] acc_sum;
    logic [ACC_WIDTH-1:0] acc_post;
    logic [PIX_WIDTH-1:0] post_res;

    assign advance    = !out_valid_q || bus.out_ready;
    assign in_ready   = (state_q == RUN) && advance;
    assign accept     = bus.in_valid && in_ready;
    assign k_fire     = bus.k_valid && (state_q == KLOAD);
    assign win_pos_ok = (row_cnt_q >= RW'(KERNEL_SIZE - 1)) && (col_cnt_q >= CW'(KERNEL_SIZE - 1));
    assign last_col   = (col_cnt_q == CW'(IMG_WIDTH - 1));
    assign last_row   = (row_cnt_q == RW'(IMG_HEIGHT - 1));
    assign pipe_empty = !win_valid_q && !s1_valid_q;

    conv_line_buffer #(
        .IMG_WIDTH   (IMG_WIDTH),
        .KERNEL_SIZE (KERNEL_SIZE),
        .PIX_WIDTH   (PIX_WIDTH)
    ) u_line_buffer (
        .clk     (clk),
        .wr_en   (accept),
        .addr    (col_cnt_q),
        .wr_data (bus.in_data),
        .rd_data (lb_rd)
    );

    always_comb begin
        state_d   = state_q;
        k_cnt_d   = k_cnt_q;
        col_cnt_d = col_cnt_q;
        row_cnt_d = row_cnt_q;
        shift_d   = shift_q;
        sat_d     = sat_q;
        done_d    = 1'b0;
        kern_d    = kern_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = KLOAD;
                    k_cnt_d   = '0;
                    col_cnt_d = '0;
                    row_cnt_d = '0;
                    shift_d   = cfg_shift;
                    sat_d     = cfg_saturate;
                end
            end
            KLOAD: begin
                if (k_fire) begin
                    kern_d[k_cnt_q] = bus.k_data;
                    k_cnt_d         = k_cnt_q + 1'b1;
                    if (k_cnt_q == KW'(KK - 1)) begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (accept) begin
                    if (last_col) begin
                        col_cnt_d = '0;
                        row_cnt_d = row_cnt_q + 1'b1;
                    end else begin
                        col_cnt_d = col_cnt_q + 1'b1;
                    end
                    if (last_col && last_row) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // The last pixel always completes a window, so the final result is the
                // one presented once nothing remains behind it in the pipeline.
                if (pipe_empty && out_valid_q && bus.out_ready) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Window columns shift left on each accepted pixel; the rightmost column is the
    // buffered rows above plus the incoming pixel at the bottom.
    always_comb begin
        win_valid_d = win_valid_q;
        s1_valid_d  = s1_valid_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        win_d       = win_q;
        prod_d      = prod_q;
        if (accept) begin
            for (int i = 0; i < KERNEL_SIZE; i++) begin
                for (int j = 0; j < KERNEL_SIZE - 1; j++) begin
                    win_d[i][j] = win_q[i][j+1];
                end
            end
            for (int i = 0; i < KERNEL_SIZE - 1; i++) begin
                win_d[i][KERNEL_SIZE-1] = lb_rd[KERNEL_SIZE-2-i];
            end
            win_d[KERNEL_SIZE-1][KERNEL_SIZE-1] = bus.in_data;
        end
        if (advance) begin
            win_valid_d = accept && win_pos_ok;
            s1_valid_d  = win_valid_q;
            out_valid_d = s1_valid_q;
            if (win_valid_q) begin
                for (int i = 0; i < KERNEL_SIZE; i++) begin
                    for (int j = 0; j < KERNEL_SIZE; j++) begin
                        prod_d[i*KERNEL_SIZE+j] = PRW'(win_q[i][j]) * PRW'(kern_q[i*KERNEL_SIZE+j]);
                    end
                end
            end
            if (s1_valid_q) begin
                out_data_d = post_res;
            end
        end
    end

    always_comb begin
        acc_sum = '0;
        for (int n = 0; n < KK; n++) begin
            acc_sum = acc_sum + ACC_WIDTH'(prod_q[n]);
        end
        acc_post = acc_sum >> shift_q;
        if (sat_q && (acc_post > PIX_MAX)) begin
            post_res = '1;
        end else begin
            post_res = acc_post[PIX_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            k_cnt_q     <= '0;
            col_cnt_q   <= '0;
            row_cnt_q   <= '0;
            shift_q     <= '0;
            sat_q       <= 1'b0;
            done_q      <= 1'b0;
            win_valid_q <= 1'b0;
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            k_cnt_q     <= k_cnt_d;
            col_cnt_q   <= col_cnt_d;
            row_cnt_q   <= row_cnt_d;
            shift_q     <= shift_d;
            sat_q       <= sat_d;
            done_q      <= done_d;
            win_valid_q <= win_valid_d;
            s1_valid_q  <= s1_valid_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    // Data-only registers; every entry is rewritten before a valid flag depends on it.
    always_ff @(posedge clk) begin
        kern_q <= kern_d;
        win_q  <= win_d;
        prod_q <= prod_d;
    end

    assign bus.k_ready   = (state_q == KLOAD);
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign busy          = (state_q != IDLE);
    assign done          = done_q;

endmodule

// File: tb/tb_conv2d_stream_engine.sv
// Directed bench for conv2d_stream_engine on an 8x8 frame with a 4x4 kernel;
// expected result streams are hand-derived closed forms for each stimulus pattern.
module tb_conv2d_stream_engine;

    localparam int W    = 8;
    localparam int H    = 8;
    localparam int K    = 4;
    localparam int PW   = 8;
    localparam int NPIX = W * H;
    localparam int OW   = W - K + 1;
    localparam int OH   = H - K + 1;
    localparam int NOUT = OW * OH;
    localparam int KK   = K * K;

    logic       clk;
    logic       reset;
    logic       start;
    logic [4:0] cfg_shift;
    logic       cfg_saturate;
    logic       busy;
    logic       done;

    int checks   = 0;
    int failures = 0;
    int pix     [NPIX];
    int kern    [KK];
    int exp_res [NOUT];

    conv2d_stream_engine_if #(.PIX_WIDTH(PW)) bus ();

    conv2d_stream_engine #(
        .IMG_WIDTH   (W),
        .IMG_HEIGHT  (H),
        .KERNEL_SIZE (K),
        .PIX_WIDTH   (PW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .cfg_shift    (cfg_shift),
        .cfg_saturate (cfg_saturate),
        .bus          (bus),
        .busy         (busy),
        .done         (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic fill_const(input int kval, input int pval, input int res);
        for (int n = 0; n < KK; n++) kern[n] = kval;
        for (int n = 0; n < NPIX; n++) pix[n] = pval;
        for (int n = 0; n < NOUT; n++) exp_res[n] = res;
    endtask

    task automatic fill_identity();
        for (int n = 0; n < KK; n++) kern[n] = (n == 0) ? 1 : 0;
        for (int n = 0; n < NPIX; n++) pix[n] = n % 256;
        for (int r = 0; r < OH; r++)
            for (int c = 0; c < OW; c++)
                exp_res[r*OW+c] = (r * W + c) % 256;
    endtask

    // All-ones kernel over pixel = index: the 4x4 window sum at (r,c) is 128r + 16c + 216.
    task automatic fill_ramp_ones(input int shift, input bit sat);
        int v;
        for (int n = 0; n < KK; n++) kern[n] = 1;
        for (int n = 0; n < NPIX; n++) pix[n] = n;
        for (int r = 0; r < OH; r++)
            for (int c = 0; c < OW; c++) begin
                v = (128 * r + 16 * c + 216) >> shift;
                exp_res[r*OW+c] = sat ? ((v > 255) ? 255 : v) : (v % 256);
            end
    endtask

    task automatic apply_reset();
        reset         = 1'b1;
        start         = 1'b0;
        cfg_shift     = 5'd0;
        cfg_saturate  = 1'b0;
        bus.k_valid   = 1'b0;
        bus.k_data    = '0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic start_frame(input int shift, input bit sat);
        int n;
        int guard;
        start        = 1'b1;
        cfg_shift    = 5'(shift);
        cfg_saturate = sat;
        @(negedge clk);
        start        = 1'b0;
        cfg_shift    = 5'd7;
        cfg_saturate = !sat;
        n = 0;
        guard = 0;
        while (n < KK && guard < 100) begin
            bus.k_valid = 1'b1;
            bus.k_data  = 8'(kern[n]);
            #1;
            if (bus.k_ready) n++;
            @(negedge clk);
            guard++;
        end
        bus.k_valid = 1'b0;
        check("kernel_handshakes", n, KK);
    endtask

    task automatic run_frame(input bit rand_ready, input bit disturb);
        int pi;
        int ri;
        int cyc;
        bit prev_stall;
        bit early_done;
        logic [PW-1:0] held;
        pi = 0;
        ri = 0;
        cyc = 0;
        prev_stall = 1'b0;
        early_done = 1'b0;
        held = '0;
        while (ri < NOUT && cyc < 4000) begin
            bus.out_ready = rand_ready ? ($urandom_range(0, 99) < 30) : 1'b1;
            if (pi < NPIX) begin
                bus.in_valid = 1'b1;
                bus.in_data  = 8'(pix[pi]);
            end else begin
                bus.in_valid = 1'b0;
                bus.in_data  = '0;
            end
            if (disturb) begin
                start       = (pi >= 10 && pi < 13);
                bus.k_valid = (pi >= 10 && pi < 13);
                bus.k_data  = 8'hAA;
            end
            #1;
            if (prev_stall) begin
                check("stall_valid", bus.out_valid, 1);
                check("stall_hold", bus.out_data, held);
            end
            if (done) early_done = 1'b1;
            if (bus.out_valid && bus.out_ready) begin
                check($sformatf("result[%0d]", ri), bus.out_data, exp_res[ri]);
                ri++;
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            held = bus.out_data;
            if (bus.in_valid && bus.in_ready) pi++;
            @(negedge clk);
            cyc++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.k_valid   = 1'b0;
        start         = 1'b0;
        #1;
        check("results_seen", ri, NOUT);
        check("pixels_taken", pi, NPIX);
        check("early_done", early_done, 0);
        check("done_pulse", done, 1);
        check("busy_after", busy, 0);
        check("valid_after", bus.out_valid, 0);
        @(negedge clk);
        #1;
        check("done_cleared", done, 0);
        @(negedge clk);
    endtask

    initial begin
        int pi;
        int guard;

        apply_reset();
        #1;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_out_valid", bus.out_valid, 0);
        check("reset_out_data", bus.out_data, 0);
        check("reset_k_ready", bus.k_ready, 0);
        check("reset_in_ready", bus.in_ready, 0);

        fill_const(1, 1, 16);
        start_frame(0, 0);
        run_frame(1'b0, 1'b0);

        fill_const(255, 255, 255);
        start_frame(0, 1);
        run_frame(1'b0, 1'b0);

        fill_const(255, 255, 16);
        start_frame(0, 0);
        run_frame(1'b0, 1'b0);

        fill_identity();
        start_frame(0, 0);
        run_frame(1'b0, 1'b0);

        fill_ramp_ones(0, 1'b1);
        start_frame(0, 1);
        run_frame(1'b0, 1'b0);

        fill_ramp_ones(2, 1'b0);
        start_frame(2, 0);
        run_frame(1'b0, 1'b0);

        fill_identity();
        start_frame(0, 0);
        run_frame(1'b1, 1'b0);

        // Abort a frame after 20 pixels, then run a clean frame.
        fill_const(1, 1, 16);
        start_frame(0, 0);
        pi = 0;
        guard = 0;
        while (pi < 20 && guard < 200) begin
            bus.out_ready = 1'b1;
            bus.in_valid  = 1'b1;
            bus.in_data   = 8'(pix[pi]);
            #1;
            if (bus.in_ready) pi++;
            @(negedge clk);
            guard++;
        end
        bus.in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        #1;
        check("abort_busy", busy, 0);
        check("abort_out_valid", bus.out_valid, 0);
        check("abort_in_ready", bus.in_ready, 0);
        check("abort_done", done, 0);
        reset = 1'b0;
        @(negedge clk);
        fill_identity();
        start_frame(0, 0);
        run_frame(1'b0, 1'b0);

        // Coefficients offered while idle and start/k_valid during RUN must be ignored.
        bus.k_valid = 1'b1;
        bus.k_data  = 8'h55;
        #1;
        check("idle_k_ready", bus.k_ready, 0);
        @(negedge clk);
        @(negedge clk);
        bus.k_valid = 1'b0;
        fill_ramp_ones(0, 1'b1);
        start_frame(0, 1);
        run_frame(1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
